csa_sum_sequencer: RTL and testbench

- Streaming controller that sums a burst of 1..2^CNT_W-1 unsigned 32-bit operands using one shared 4-input carry-save multi-operand adder (multiple_adder_csa_4x32, instantiated inside).
- Collects operands four at a time over a valid/ready input, issues each group to the adder and accumulates the 35-bit group sums into a wide accumulator.
- Presents the final total on a valid/ready output.
- Sits between an operand producer (DMA/FIFO) and a result consumer in the arithmetic subsystem.

---
 rtl/csa_sum_sequencer.sv | 174 +++++++++++++++++
 tb/tb_csa_sum_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_sum_sequencer.sv
// csa_sum_sequencer: sums a burst of unsigned 32-bit operands, four at a time,
// through one shared carry-save 4-operand adder into a wide accumulator.
// multiple_adder_csa_4x32 is the shared adder and lives in this file as well.

// Four-operand 32-bit adder: two 3:2 carry-save layers followed by one carry-propagate add.
module multiple_adder_csa_4x32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  input  logic [31:0] w,
  output logic [34:0] sum
);

  logic [32:0] s1;
  logic [32:0] c1;
  logic [32:0] w_ext;
  logic [33:0] s2;
  logic [33:0] c2;

  // First layer compresses x, y, z into a sum/carry pair; second layer folds in w.
  always_comb begin
    s1    = {1'b0, x ^ y ^ z};
    c1    = {(x & y) | (x & z) | (y & z), 1'b0};
    w_ext = {1'b0, w};
    s2    = {1'b0, s1 ^ c1 ^ w_ext};
    c2    = {(s1 & c1) | (s1 & w_ext) | (c1 & w_ext), 1'b0};
    sum   = {1'b0, s2} + {1'b0, c2};
  end

endmodule

module csa_sum_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   op_count,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32+CNT_W-1:0] out_sum
);

  localparam int ACC_W = 32 + CNT_W;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    ADD,
    DONE
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [31:0]       slot_x;
  logic [31:0]       slot_y;
  logic [31:0]       slot_z;
  logic [31:0]       slot_w;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        slot_idx;
  logic [34:0]       group_sum;
  logic              last_slot;

  // The adder sees only slot registers, so in_data never reaches out_sum combinationally.
  multiple_adder_csa_4x32 u_adder (
    .x   (slot_x),
    .y   (slot_y),
    .z   (slot_z),
    .w   (slot_w),
    .sum (group_sum)
  );

  // Accumulator update applied in ADD, and the condition that closes a group in COLLECT.
  always_comb begin
    acc_next  = acc + ACC_W'(group_sum);
    last_slot = (slot_idx == 2'd3) || (remaining == CNT_W'(1));
  end

  // Sequencer FSM; busy, in_ready, out_valid and out_sum are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      acc       <= '0;
      slot_x    <= '0;
      slot_y    <= '0;
      slot_z    <= '0;
      slot_w    <= '0;
      remaining <= '0;
      slot_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            busy <= 1'b1;
            if (op_count != '0) begin
              slot_x    <= '0;
              slot_y    <= '0;
              slot_z    <= '0;
              slot_w    <= '0;
              remaining <= op_count;
              slot_idx  <= '0;
              in_ready  <= 1'b1;
              state     <= COLLECT;
            end else begin
              out_sum   <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        COLLECT: begin
          if (in_valid && in_ready) begin
            case (slot_idx)
              2'd0:    slot_x <= in_data;
              2'd1:    slot_y <= in_data;
              2'd2:    slot_z <= in_data;
              default: slot_w <= in_data;
            endcase
            slot_idx  <= slot_idx + 2'd1;
            remaining <= remaining - CNT_W'(1);
            if (last_slot) begin
              in_ready <= 1'b0;
              state    <= ADD;
            end
          end
        end

        ADD: begin
          acc      <= acc_next;
          slot_x   <= '0;
          slot_y   <= '0;
          slot_z   <= '0;
          slot_w   <= '0;
          slot_idx <= '0;
          if (remaining == '0) begin
            out_sum   <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= COLLECT;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_sum_sequencer.sv
// Self-checking bench for csa_sum_sequencer: randomized bursts compared
// against a plain-arithmetic sum of the operands sent.
module tb_csa_sum_sequencer;

  localparam int CNT_W = 8;
  localparam int ACC_W = 32 + CNT_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  op_count;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] operands [256];

  csa_sum_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_count  (op_count),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one burst of n operands from operands[], with gap_pct percent idle in_valid
  // cycles, holding the result hold cycles before acknowledging it. Inputs change and
  // outputs are observed on the falling edge.
  task automatic applyStimulus(input int n, input int gap_pct, input int hold, input bit poke_start);
    logic [63:0] expected_sum;
    int  idx;
    int  adds;
    int  cycles;
    bit  seen_ready;
    bit  busy_ok;
    bit  excl_ok;
    bit  done;
    expected_sum = 64'd0;
    for (int i = 0; i < n; i++) expected_sum += 64'(operands[i]);
    idx = 0; adds = 0; cycles = 0;
    seen_ready = 1'b0; busy_ok = 1'b1; excl_ok = 1'b1; done = 1'b0;

    @(negedge clk);
    start    = 1'b1;
    op_count = n[CNT_W-1:0];
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;

    while (!done && cycles < 5000) begin
      if (in_ready && out_valid) excl_ok = 1'b0;
      if (out_valid) begin
        done = 1'b1;
      end else begin
        cycles++;
        if (!busy) busy_ok = 1'b0;
        if (in_ready) seen_ready = 1'b1;
        else adds++;
        if (in_ready && idx < n && $urandom_range(99) >= gap_pct) begin
          in_valid = 1'b1;
          in_data  = operands[idx];
          idx++;
        end else begin
          in_valid = 1'b0;
          in_data  = $urandom;
        end
        if (poke_start && cycles == 2) begin
          start    = 1'b1;
          op_count = CNT_W'($urandom);
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;

    if (!done) begin
      checkOutput("timeout", 64'd0, 64'd1);
      return;
    end

    checkOutput("sum", 64'(out_sum), expected_sum);
    checkOutput("handshakes", 64'(idx), 64'(n));
    checkOutput("add_cycles", 64'(adds), 64'((n + 3) / 4));
    if (gap_pct == 0) checkOutput("latency", 64'(cycles), 64'(n + (n + 3) / 4));
    checkOutput("busy_high", 64'(busy_ok), 64'd1);
    checkOutput("ready_seen", 64'(seen_ready), 64'(n != 0));

    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        start    = 1'b1;
        op_count = CNT_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (in_ready && out_valid) excl_ok = 1'b0;
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_sum", 64'(out_sum), expected_sum);
      checkOutput("hold_busy", 64'(busy), 64'd1);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("ack_valid", 64'(out_valid), 64'd0);
    checkOutput("ack_busy", 64'(busy), 64'd0);
    checkOutput("exclusive", 64'(excl_ok), 64'd1);
  endtask

  // Starts a 6-operand burst, resets after 3 handshakes and checks outputs clear at once.
  task automatic applyMidBurstReset();
    int taken;
    int guard;
    taken = 0;
    guard = 0;
    @(negedge clk);
    start    = 1'b1;
    op_count = CNT_W'(6);
    @(negedge clk);
    start = 1'b0;
    while (taken < 3 && guard < 100) begin
      guard++;
      if (in_ready) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        taken++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_idle", 64'(busy), 64'd0);
  endtask

  // Directed corner bursts followed by randomized ones.
  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    op_count  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #22;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_sum", 64'(out_sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) operands[i] = 32'(i + 1);
    applyStimulus(4, 0, 0, 1'b0);

    for (int i = 0; i < 5; i++) operands[i] = 32'hFFFF_FFFF;
    applyStimulus(5, 0, 0, 1'b0);

    for (int i = 0; i < 255; i++) operands[i] = 32'hFFFF_FFFF;
    applyStimulus(255, 30, 0, 1'b0);

    applyStimulus(0, 0, 0, 1'b0);

    for (int i = 0; i < 7; i++) operands[i] = $urandom;
    applyStimulus(7, 0, 10, 1'b1);

    applyMidBurstReset();
    operands[0] = 32'd7;
    operands[1] = 32'd8;
    applyStimulus(2, 0, 0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) operands[i] = $urandom;
      applyStimulus(n, int'($urandom_range(0, 50)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
